// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle for the iterative RV32M unit
interface muldiv_seq_if;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        valid_o;
    logic        ack_i;
    logic [31:0] result_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i, ack_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i, ack_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide, shared 64-bit datapath, 32 iterations
module muldiv_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  op;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic [31:0] result;

    logic        accept, signed_a, signed_b, div_zero, div_ovf, special;
    logic [31:0] abs_a, abs_b, special_res;
    logic [32:0] mul_sum, rem_sh;
    logic [33:0] div_diff;
    logic [63:0] acc_step, prod_s;
    logic [31:0] fix_res;

    assign accept   = (state == IDLE) && bus.valid_i && !bus.flush_i;
    assign signed_a = !(bus.op_i == 3'b011 || bus.op_i == 3'b101 || bus.op_i == 3'b111);
    assign signed_b = signed_a && (bus.op_i != 3'b010);
    assign abs_a    = (signed_a && bus.a_i[31]) ? (32'd0 - bus.a_i) : bus.a_i;
    assign abs_b    = (signed_b && bus.b_i[31]) ? (32'd0 - bus.b_i) : bus.b_i;

    // Results that bypass the iteration entirely (RISC-V defined outcomes)
    assign div_zero    = bus.op_i[2] && (bus.b_i == 32'd0);
    assign div_ovf     = (bus.op_i == 3'b100 || bus.op_i == 3'b110)
                         && (bus.a_i == 32'h8000_0000) && (bus.b_i == 32'hFFFF_FFFF);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (bus.op_i[1] ? bus.a_i : 32'hFFFF_FFFF)
                                  : (bus.op_i[1] ? 32'd0   : 32'h8000_0000);

    // Multiply: acc = {partial, multiplier}; carry-out of the add shifts into bit 63.
    assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
    // Divide: acc = {rem, quot}; remainder is widened to 33 bits so the shift never drops a bit.
    assign rem_sh   = acc[63:31];
    assign div_diff = {1'b0, rem_sh} - {2'b00, mag_b};
    assign acc_step = op[2] ? (div_diff[33] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                            : {div_diff[31:0], acc[30:0], 1'b1})
                            : {mul_sum, acc[31:1]};

    assign prod_s = (sa ^ sb) ? (64'd0 - acc) : acc;

    always_comb begin
        fix_res = 32'd0;
        case (op)
            3'b000:                 fix_res = prod_s[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[63:32];
            3'b100:                 fix_res = (sa ^ sb) ? (32'd0 - acc[31:0]) : acc[31:0];
            3'b101:                 fix_res = acc[31:0];
            3'b110:                 fix_res = sa ? (32'd0 - acc[63:32]) : acc[63:32];
            default:                fix_res = acc[63:32];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : BUSY;
            BUSY: if (cnt == 5'd31) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (bus.ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op     <= 3'd0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op    <= bus.op_i;
                    sa    <= signed_a && bus.a_i[31];
                    sb    <= signed_b && bus.b_i[31];
                    mag_a <= abs_a;
                    mag_b <= abs_b;
                    acc   <= bus.op_i[2] ? {32'd0, abs_a} : {32'd0, abs_b};
                    cnt   <= 5'd0;
                    if (special) result <= special_res;
                end
                BUSY: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                end
                FIX: result <= fix_res;
                default: ;
            endcase
            if (bus.flush_i) cnt <= 5'd0;
        end
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result;
endmodule
